// File: rtl/sub_bytes_lanes.sv
`timescale 1ns/1ps
// AES SubBytes over LANES S-box lanes per cycle, 16/LANES cycles per state, result held under out_ready backpressure.
// Define SUBBYTES_INV_EN to pair every lane with an inverse S-box selected by the latched in_mode.
module sub_bytes_lanes #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int P  = 16 / LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = 8 * LANES;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_lanes: LANES must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

`ifdef SUBBYTES_INV_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  logic mode_q;
`else
  logic unused_in_mode;
  assign unused_in_mode = in_mode;
`endif

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pass;
  logic [127:0]  in_reg;
  logic [127:0]  res_reg;
  logic          accept;
  logic          last_pass;
  logic [6:0]    grp_base;
  logic [GW-1:0] grp_in;
  logic [GW-1:0] grp_out;

  assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last_pass = (pass == CW'(P - 1));
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign data_out  = res_reg;

  // pass 0 works on the most significant byte group
  assign grp_base = 7'((P - 1 - int'(pass)) * GW);
  assign grp_in   = in_reg[grp_base +: GW];

  always_comb begin
    grp_out = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef SUBBYTES_INV_EN
      grp_out[8*l +: 8] = mode_q ? sbox_inv(grp_in[8*l +: 8]) : sbox_fwd(grp_in[8*l +: 8]);
`else
      grp_out[8*l +: 8] = sbox_fwd(grp_in[8*l +: 8]);
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SUB;
      SUB:  if (last_pass) state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = SUB;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      pass    <= '0;
      in_reg  <= '0;
      res_reg <= '0;
`ifdef SUBBYTES_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        in_reg <= data_in;
        pass   <= '0;
`ifdef SUBBYTES_INV_EN
        mode_q <= in_mode;
`endif
      end else if (state == SUB) begin
        pass <= last_pass ? '0 : pass + 1'b1;
      end
      if (state == SUB) res_reg[grp_base +: GW] <= grp_out;
    end
  end

endmodule

// File: doc/sub_bytes_lanes.md
# sub_bytes_lanes

Parametrised AES SubBytes engine for the cipher datapath: accepts a 128-bit state over a valid/ready handshake, substitutes all 16 bytes using LANES S-box instances per cycle, and presents the result over a second valid/ready handshake. It replaces the fixed 4-lane substitute stage between AddRoundKey and ShiftRows. Lane count trades area for latency, and a compile-time option adds inverse S-box support for decryption.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error
- clk  input  1  clock, rising edge
- n_rst  input  1  reset; one clock, asynchronous, active-low
- in_valid  input  1  data_in and in_mode valid
- in_ready  output  1  block can accept a state this cycle
- in_mode  input  1  0 = forward S-box, 1 = inverse S-box; sampled only on an accepted transfer
- data_in  input  128  state; byte 15 = data_in[127:120], byte 0 = data_in[7:0]
- out_valid  output  1  data_out holds a completed result
- out_ready  input  1  downstream accepts the result
- data_out  output  128  substituted state, same byte order as data_in
- busy  output  1  high in any state other than IDLE

## Operation
- P = 16/LANES passes per state. Pass counter width = max(1, clog2(P)).
- Accept: in_valid & in_ready at a rising edge. Latch data_in and in_mode into the input register, clear the pass counter, go to SUB.
- FSM states:
  - IDLE: in_ready=1. Accept -> SUB.
  - SUB: pass i substitutes bytes 15-i·LANES down to 16-(i+1)·LANES, MSB group first. Each byte is written to the same position of the result register. On pass P-1 -> HOLD.
  - HOLD: out_valid=1. out_ready=1 with no accept -> IDLE. out_ready=1 with in_valid=1 -> accept the new state, go to SUB. out_ready=0 -> stay in HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). in_ready is combinational from out_ready; no combinational path exists from in_valid to any output.
- data_out is driven directly from the result register.
  - Stable while out_valid=1.
  - May hold partial or stale bytes while out_valid=0.
- Each S-box lane is combinational. The input register is not modified during SUB; the lane mux selects the byte group by pass index.
- Reset values: state IDLE, pass counter 0, input register 0, result register 0, mode 0. Resulting outputs: in_ready=1, out_valid=0, busy=0, data_out=0.

## Timing
- Accept at edge k. Pass i is computed in cycle k+i and registered at edge k+i+1. out_valid rises at edge k+P.
- Latency is P cycles: LANES=16 -> 1, 4 -> 4, 1 -> 16.
- With out_ready held high and in_valid held high, out_valid pulses high for 1 cycle every P+1 cycles and is low for exactly P cycles between results.
- Backpressure: out_valid and data_out hold indefinitely while out_ready=0; in_ready=0 throughout.
- in_valid during SUB is ignored; in_ready=0, so no transfer occurs.
- n_rst asserted mid-SUB or mid-HOLD: all outputs take their reset values immediately, without waiting for a clock edge. The in-flight state is discarded, and no out_valid is produced for it after release.

## Configuration
- SUBBYTES_INV_EN defined: each lane is a forward and inverse S-box pair, selected by the latched mode bit.
- SUBBYTES_INV_EN undefined:
  - Only forward S-boxes are built.
  - in_mode is ignored, and the mode register is not synthesised.
  - Every accepted state is forward-substituted.

## Test plan
- Reset, then accept data_in=0x00…00, mode 0, LANES=4 -> out_valid at edge k+4, data_out=0x6363…63; in_ready=0 for 4 cycles after the accept.
- FIPS-197 round 1 input 0x193de3bea0f4e22b9ac68d2ae9f84808, swept over LANES=1, 2, 4, 8, 16 -> data_out=0xd42711aee0bf98f1b8b45de51e415230; latency 16, 8, 4, 2, 1.
- SUBBYTES_INV_EN defined, mode 1, data_in=0xd42711aee0bf98f1b8b45de51e415230 -> data_out=0x193de3bea0f4e22b9ac68d2ae9f84808. Same stimulus with mode 0 and the macro undefined -> forward result.
- HOLD with out_ready=0 for 10 cycles -> data_out unchanged, in_ready=0. Then out_ready=1 with in_valid=1 -> new state accepted that edge, out_valid low for exactly P cycles.
- Streaming with out_ready=1 and in_valid=1 for 5 states -> 5 correct results in order, one every P+1 cycles.
- n_rst pulsed low during pass 2 with LANES=4 -> out_valid=0, busy=0, data_out=0 immediately. No spurious out_valid after release, and the next state processes correctly.
